// File: rtl/fpu_cmd_queue.sv
// fpu_cmd_queue: command FIFO feeding a single-issue FPU core, with local sign/move ops and in-order results
module fpu_cmd_queue #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [2:0]               in_op,
   input  logic [31:0]              in_a,
   input  logic [31:0]              in_b,
   input  logic [TAG_W-1:0]         in_tag,
   output logic                     core_start,
   output logic [2:0]               core_op,
   output logic [31:0]              core_n1,
   output logic [31:0]              core_n2,
   input  logic [31:0]              core_result,
   input  logic                     core_done,
   input  logic                     core_busy,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_result,
   output logic [TAG_W-1:0]         out_tag,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;
   state_t            state, next_state;
   logic [2:0]        op_mem  [DEPTH];
   logic [31:0]       a_mem   [DEPTH];
   logic [31:0]       b_mem   [DEPTH];
   logic [TAG_W-1:0]  tag_mem [DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [2:0]        head_op;
   logic [31:0]       head_a, head_b, local_res;
   logic [TAG_W-1:0]  head_tag;
   logic              push, pop, start_d, valid_d;
   // FSM state register
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else     state <= next_state;
   // Next state: pop only when idle, nothing pending at the output and the core is free
   always_comb begin
      pop        = state == IDLE && count != '0 && !out_valid && !core_busy;
      next_state = pop                                     ? (head_op[2] ? OUT : ISSUE) :
                   state == ISSUE                          ? WAIT :
                   (state == WAIT && core_done)            ? OUT  :
                   (state == OUT && out_valid && out_ready) ? IDLE : state;
   end
   // Outputs decoded from state, plus FIFO head and local op results
   always_comb begin
      in_ready  = count < (AW+1)'(DEPTH);
      push      = in_valid && in_ready;
      head_op   = op_mem[rd_ptr];
      head_a    = a_mem[rd_ptr];
      head_b    = b_mem[rd_ptr];
      head_tag  = tag_mem[rd_ptr];
      start_d   = state == ISSUE;
      valid_d   = state == OUT && !(out_valid && out_ready);
      local_res = head_op[1:0] == 2'b00 ? {~head_a[31], head_a[30:0]} :
                  head_op[1:0] == 2'b01 ? head_a :
                  head_op[1:0] == 2'b10 ? {1'b0, head_a[30:0]} : 32'h7FC0_0000;
   end
   // FIFO storage has no reset so it can map to plain RAM
   always_ff @(posedge clk)
      if (push) begin
         op_mem[wr_ptr]  <= in_op;
         a_mem[wr_ptr]   <= in_a;
         b_mem[wr_ptr]   <= in_b;
         tag_mem[wr_ptr] <= in_tag;
      end
   // Pointers, occupancy, core operand latch and registered result outputs
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         core_start <= 1'b0;
         core_op    <= '0;
         core_n1    <= '0;
         core_n2    <= '0;
         out_valid  <= 1'b0;
         out_result <= '0;
         out_tag    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) begin
            rd_ptr  <= rd_ptr + AW'(1);
            out_tag <= head_tag;
            if (head_op[2]) out_result <= local_res;
            else begin
               core_op <= head_op;
               core_n1 <= head_a;
               core_n2 <= head_b;
            end
         end
         if (state == WAIT && core_done) out_result <= core_result;
         count      <= count + (AW+1)'(push) - (AW+1)'(pop);
         core_start <= start_d;
         out_valid  <= valid_d;
      end
endmodule
